// File: rtl/idu_pkg.sv
// idu shared constants, field layout of the dynamic instruction
// word and the decode-side types.
package idu_pkg;

  localparam int DATA_WIDTH     = 64;
  localparam int INST_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 32;
  localparam int ALUOP_WIDTH    = 4;

  localparam logic [ALUOP_WIDTH-1:0] ADD_ALUOP = 4'd1;

  // Field offsets, LSB first; mirrors dyn_inst_t below.
  localparam int USE_IMM_DYNOFF = 0;
  localparam int USE_RS2_DYNOFF = 1;
  localparam int USE_RS1_DYNOFF = 2;
  localparam int USE_RD_DYNOFF  = 3;
  localparam int RD_DYNOFF      = 4;
  localparam int IMM_DYNOFF     = RD_DYNOFF + REG_ADDR_WIDTH;
  localparam int RS2VAL_DYNOFF  = IMM_DYNOFF + DATA_WIDTH;
  localparam int RS1VAL_DYNOFF  = RS2VAL_DYNOFF + DATA_WIDTH;
  localparam int ALUOP_DYNOFF   = RS1VAL_DYNOFF + DATA_WIDTH;
  localparam int DYN_INST_WIDTH = ALUOP_DYNOFF + ALUOP_WIDTH;

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] SYSTEM = 7'h73;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [6:0] F7_ADD = 7'h00;

  localparam logic [INST_WIDTH-1:0] EBREAK_INST = 32'h00100073;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic [ALUOP_WIDTH-1:0]    aluop;
    logic [DATA_WIDTH-1:0]     rs1val;
    logic [DATA_WIDTH-1:0]     rs2val;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      use_rd;
    logic                      use_rs1;
    logic                      use_rs2;
    logic                      use_imm;
  } dyn_inst_t;

  function automatic logic [DATA_WIDTH-1:0] imm_i(
    input logic [INST_WIDTH-1:0] inst
  );
    return {{(DATA_WIDTH-12){inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] imm_u(
    input logic [INST_WIDTH-1:0] inst
  );
    return {{(DATA_WIDTH-32){inst[31]}}, inst[31:12], 12'b0};
  endfunction

endpackage

// File: rtl/idu_regfile.sv
// Integer register file: two async read ports, one sync write
// port, x0 hardwired to zero, x10 exported.
module idu_regfile
  import idu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0]     rs1_data,
  output logic [DATA_WIDTH-1:0]     rs2_data,
  input  logic                      we,
  input  logic [REG_ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH-1:0]     a0
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rs1_data = (rs1_addr == '0) ? '0
                                     : regs_q[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0
                                     : regs_q[rs2_addr];
  assign a0       = regs_q[10];

endmodule

// File: rtl/idu.sv
// Decode stage: decodes addi/add/lui/ebreak, reads the regfile
// with write-back bypass and registers one dynamic instruction.
module idu
  import idu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [INST_WIDTH-1:0]     inst_ifu_i,
  input  logic                      inst_valid_ifu_i,
  output logic                      inst_ready_ifu_o,
  output logic [DYN_INST_WIDTH-1:0] dyn_instr_exeu_o,
  output logic                      dyn_valid_exeu_o,
  input  logic [DATA_WIDTH-1:0]     wrtbck_val_exeu_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_exeu_i,
  input  logic                      wrtbck_en_exeu_i,
  output logic                      halt_o,
  output logic                      illegal_o,
  output logic [DATA_WIDTH-1:0]     a0_o
);

  state_t    state_q;
  state_t    state_d;
  logic      illegal_q;
  logic      illegal_d;
  dyn_inst_t dyn_q;
  dyn_inst_t dyn_d;
  logic      dyn_valid_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  logic [REG_ADDR_WIDTH-1:0] rd_a;
  logic [REG_ADDR_WIDTH-1:0] rs1_a;
  logic [REG_ADDR_WIDTH-1:0] rs2_a;

  logic [DATA_WIDTH-1:0] rf_rs1;
  logic [DATA_WIDTH-1:0] rf_rs2;
  logic [DATA_WIDTH-1:0] rs1_val;
  logic [DATA_WIDTH-1:0] rs2_val;

  logic we;
  logic fire;
  logic is_ebreak;
  logic is_addi;
  logic is_add;
  logic is_lui;
  logic dec_halt;
  logic dec_illegal;

  assign opcode = inst_ifu_i[6:0];
  assign funct3 = inst_ifu_i[14:12];
  assign funct7 = inst_ifu_i[31:25];
  assign rd_a   = inst_ifu_i[11:7];
  assign rs1_a  = inst_ifu_i[19:15];
  assign rs2_a  = inst_ifu_i[24:20];

  assign is_ebreak = (inst_ifu_i == EBREAK_INST);
  assign is_addi   = (opcode == OP_IMM)
                   & (funct3 == F3_ADD);
  assign is_add    = (opcode == OP)
                   & (funct3 == F3_ADD)
                   & (funct7 == F7_ADD);
  assign is_lui    = (opcode == LUI);

  // Execute is combinational: write-back belongs to dyn_q.
  assign we = wrtbck_en_exeu_i
            & dyn_valid_q
            & (rd_exeu_i != '0);

  idu_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1_a),
    .rs2_addr (rs2_a),
    .rs1_data (rf_rs1),
    .rs2_data (rf_rs2),
    .we       (we),
    .waddr    (rd_exeu_i),
    .wdata    (wrtbck_val_exeu_i),
    .a0       (a0_o)
  );

  assign rs1_val = (we && (rd_exeu_i == rs1_a))
                 ? wrtbck_val_exeu_i : rf_rs1;
  assign rs2_val = (we && (rd_exeu_i == rs2_a))
                 ? wrtbck_val_exeu_i : rf_rs2;

  always_comb begin
    dyn_d       = '0;
    dec_halt    = 1'b0;
    dec_illegal = 1'b0;
    unique case (1'b1)
      is_ebreak: begin
        dec_halt = 1'b1;
      end
      is_addi: begin
        dyn_d.aluop   = ADD_ALUOP;
        dyn_d.rs1val  = rs1_val;
        dyn_d.imm     = imm_i(inst_ifu_i);
        dyn_d.rd      = rd_a;
        dyn_d.use_rd  = 1'b1;
        dyn_d.use_rs1 = 1'b1;
        dyn_d.use_imm = 1'b1;
      end
      is_add: begin
        dyn_d.aluop   = ADD_ALUOP;
        dyn_d.rs1val  = rs1_val;
        dyn_d.rs2val  = rs2_val;
        dyn_d.rd      = rd_a;
        dyn_d.use_rd  = 1'b1;
        dyn_d.use_rs1 = 1'b1;
        dyn_d.use_rs2 = 1'b1;
      end
      is_lui: begin
        dyn_d.aluop   = ADD_ALUOP;
        dyn_d.imm     = imm_u(inst_ifu_i);
        dyn_d.rd      = rd_a;
        dyn_d.use_rd  = 1'b1;
        dyn_d.use_imm = 1'b1;
      end
      default: begin
        dec_halt    = 1'b1;
        dec_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d          = state_q;
    illegal_d        = illegal_q;
    inst_ready_ifu_o = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        inst_ready_ifu_o = rst_n;
        if (fire && dec_halt) begin
          state_d   = ST_HALT;
          illegal_d = dec_illegal;
        end
      end
      ST_HALT: begin
        inst_ready_ifu_o = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign fire = inst_valid_ifu_i & inst_ready_ifu_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      illegal_q   <= 1'b0;
      dyn_q       <= '0;
      dyn_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      illegal_q   <= illegal_d;
      dyn_valid_q <= fire;
      if (fire)
        dyn_q <= dyn_d;
    end
  end

  assign dyn_instr_exeu_o = dyn_q;
  assign dyn_valid_exeu_o = dyn_valid_q;
  assign halt_o           = (state_q == ST_HALT);
  assign illegal_o        = illegal_q;

endmodule
